// File: rtl/tcs34725_pkg.sv
// tcs34725_pkg: register map, command encoding, sequencer states and init table for the TCS34725 config sequencer
package tcs34725_pkg;

    localparam logic [4:0] REG_ENABLE  = 5'h00;
    localparam logic [4:0] REG_ATIME   = 5'h01;
    localparam logic [4:0] REG_CONTROL = 5'h0F;

    localparam logic [7:0] CMD_BIT = 8'h80;
    localparam logic [7:0] EN_PON  = 8'h01;
    localparam logic [7:0] EN_AEN  = 8'h02;

    localparam int INIT_LEN = 4;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DELAY,
        S_READY
    } state_t;

    typedef struct packed {
        logic [4:0] rg;
        logic [7:0] data;
    } wr_t;

    function automatic wr_t init_entry(input logic [1:0] idx, input logic [7:0] atime,
                                       input logic [1:0] again);
        return (idx == 2'd0) ? wr_t'({REG_ENABLE, EN_PON}) :
               (idx == 2'd1) ? wr_t'({REG_ENABLE, EN_PON | EN_AEN}) :
               (idx == 2'd2) ? wr_t'({REG_ATIME, atime}) :
                               wr_t'({REG_CONTROL, 6'b0, again});
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable 32-bit down-counter; expired is high for the single cycle the count sits at 1.
module seq_timer #(
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic        expired
);

    logic [31:0] cnt;

    // A load of 0 is stretched to 1 so every delay lasts at least one cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= RST_VAL;
        else cnt <= load ? ((value == 32'd0) ? 32'd1 : value) :
                    (cnt != 32'd0) ? cnt - 32'd1 : cnt;

    assign expired = (cnt == 32'd1);

endmodule

// File: rtl/tcs34725_cfg_seq.sv
// tcs34725_cfg_seq: runs the TCS34725 power-up write sequence, then serialises host register writes
// onto the single-byte I2C write engine with gaps and a per-transaction watchdog.
module tcs34725_cfg_seq #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h29,
    parameter logic [7:0]  ATIME_INIT  = 8'hF6,
    parameter logic [1:0]  AGAIN_INIT  = 2'b01,
    parameter logic [31:0] PWRUP_CYC   = 32'd50_000,
    parameter logic [31:0] PON_CYC     = 32'd150_000,
    parameter logic [15:0] GAP_CYC     = 16'd200,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_req,
    input  logic [4:0] cfg_reg,
    input  logic [7:0] cfg_data,
    output logic       cfg_ack,
    output logic       busy,
    output logic       init_done,
    output logic       err,
    output logic       eng_enable,
    output logic [7:0] eng_add,
    output logic [7:0] eng_add_reg,
    output logic [7:0] eng_data,
    output logic [2:0] eng_num_byte,
    output logic       eng_repeat_start,
    input  logic       eng_done
);

    import tcs34725_pkg::*;

    state_t      state, nxt;
    logic [1:0]  idx;
    logic        host;
    logic [4:0]  pend_reg;
    logic [7:0]  pend_data;
    logic        dly_load, dly_exp, wd_load, wd_exp;
    logic [31:0] dly_val;
    logic        issue, finish, wr_err, take, adv;
    wr_t         ent;

    assign ent              = init_entry(idx, ATIME_INIT, AGAIN_INIT);
    assign eng_add          = {SLAVE_ADDR, 1'b0};
    assign eng_num_byte     = 3'd1;
    assign eng_repeat_start = 1'b0;
    assign busy             = (state != S_READY);

    // The delay timer starts out already counting the power-up wait
    seq_timer #(.RST_VAL((PWRUP_CYC == 32'd0) ? 32'd1 : PWRUP_CYC)) u_dly (
        .clk(clk), .rst(rst), .load(dly_load), .value(dly_val), .expired(dly_exp)
    );

    seq_timer #(.RST_VAL(32'd0)) u_wd (
        .clk(clk), .rst(rst), .load(wd_load), .value(TIMEOUT_CYC), .expired(wd_exp)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_PWRUP;
        else state <= nxt;

    always_comb begin
        nxt      = state;
        dly_load = 1'b0;
        dly_val  = {16'd0, GAP_CYC};
        wd_load  = 1'b0;
        issue    = 1'b0;
        finish   = 1'b0;
        wr_err   = 1'b0;
        take     = 1'b0;
        adv      = 1'b0;
        cfg_ack  = 1'b0;
        case (state)
            S_PWRUP: nxt = dly_exp ? S_ISSUE : S_PWRUP;
            S_ISSUE: begin
                issue   = 1'b1;
                wd_load = 1'b1;
                nxt     = S_WAIT;
            end
            S_WAIT: if (eng_done || wd_exp) begin
                finish   = 1'b1;
                wr_err   = !eng_done;
                dly_load = 1'b1;
                nxt      = S_GAP;
            end
            S_GAP: if (dly_exp) begin
                cfg_ack = host;
                adv     = !host;
                // After PON the oscillator needs its warm-up before AEN can be written
                if (host || idx == 2'(INIT_LEN - 1)) nxt = S_READY;
                else if (idx == 2'd0) begin
                    dly_load = 1'b1;
                    dly_val  = PON_CYC;
                    nxt      = S_DELAY;
                end
                else nxt = S_ISSUE;
            end
            S_DELAY: nxt = dly_exp ? S_ISSUE : S_DELAY;
            S_READY: if (cfg_req) begin
                take = 1'b1;
                nxt  = S_ISSUE;
            end
            default: nxt = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            eng_enable  <= 1'b0;
            eng_add_reg <= CMD_BIT;
            eng_data    <= 8'h00;
            init_done   <= 1'b0;
            err         <= 1'b0;
            idx         <= 2'd0;
            host        <= 1'b0;
            pend_reg    <= 5'd0;
            pend_data   <= 8'h00;
        end else begin
            if (issue) begin
                eng_enable  <= 1'b1;
                eng_add_reg <= CMD_BIT | {3'b0, host ? pend_reg : ent.rg};
                eng_data    <= host ? pend_data : ent.data;
            end
            if (finish) eng_enable <= 1'b0;
            if (wr_err) err <= 1'b1;
            if (take) begin
                host      <= 1'b1;
                pend_reg  <= cfg_reg;
                pend_data <= cfg_data;
            end
            if (adv) idx <= idx + 2'd1;
            if (nxt == S_READY && state != S_READY) init_done <= 1'b1;
        end

endmodule

// File: doc/tcs34725_cfg_seq.md
# tcs34725_cfg_seq

Configuration sequencer for the TCS34725 colour sensor that drives the single-byte I2C write engine (`LCD_Send`). After reset it runs a fixed power-up/initialisation write sequence. It then serves runtime register-write requests from the host logic, one at a time, so the engine is never shared concurrently. It owns the engine's `enable`/`done` handshake, inter-transaction gaps and a per-transaction watchdog.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h29: sensor 7-bit address. The engine address byte is `{SLAVE_ADDR,1'b0}` = 8'h52.
- `ATIME_INIT`, 8'hF6: integration-time value written at init.
- `AGAIN_INIT`, 2'b01: gain value written to CONTROL at init.
- `PWRUP_CYC`, 32'd50_000: delay from reset release to the first transaction.
- `PON_CYC`, 32'd150_000: delay after the PON write, ≥2.4 ms at 50 MHz.
- `GAP_CYC`, 16'd200: minimum cycles with `eng_enable` low between transactions.
- `TIMEOUT_CYC`, 32'd100_000: watchdog limit per transaction.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cfg_req` in 1: host write request, level. Held until `cfg_ack`.
- `cfg_reg` in 5: sensor register address, 0x00–0x1F.
- `cfg_data` in 8: value to write.
- `cfg_ack` out 1: one-cycle pulse when the host write completes or aborts.
- `busy` out 1: a transaction or delay is in progress.
- `init_done` out 1: sticky high once the init sequence finishes.
- `err` out 1: sticky, watchdog fired. Cleared only by reset.
- `eng_enable` out 1: engine enable. Held high for the whole transaction.
- `eng_add` out 8: constant `{SLAVE_ADDR,1'b0}`.
- `eng_add_reg` out 8: command byte `8'h80 | reg`. Never 8'hFE.
- `eng_data` out 8: data byte.
- `eng_num_byte` out 3: constant 3'd1.
- `eng_repeat_start` out 1: constant 0.
- `eng_done` in 1: engine completion pulse.

## Operation
- State machine: `PWRUP → ISSUE → WAIT → GAP → (DELAY) → next ISSUE … → READY`.
- Init table, in order:
  1. reg 0x00 ← 0x01 (PON), then `DELAY` for `PON_CYC`.
  2. reg 0x00 ← 0x03 (PON|AEN).
  3. reg 0x01 ← `ATIME_INIT`.
  4. reg 0x0F ← `{6'b0, AGAIN_INIT}`.
- `init_done` rises on entering `READY` after entry 4's `GAP`.
- `ISSUE`: latch `eng_add_reg`/`eng_data`, assert `eng_enable`, load the watchdog, go to `WAIT`.
- `WAIT`: on `eng_done`, deassert `eng_enable` the next cycle and go to `GAP`. If the watchdog expires first, deassert `eng_enable`, set `err`, and go to `GAP` as if done. A failed init entry is not retried; the sequence continues.
- `GAP`: hold `eng_enable` low for `GAP_CYC` cycles. This also satisfies the engine's requirement that `enable` be low to reset its internal counters.
- `READY`: sample `cfg_req` only here. Latch `cfg_reg`/`cfg_data` and go to `ISSUE`.
  - `cfg_ack` pulses in the cycle `GAP` completes for a host transaction, including a timed-out one.
  - The controller then returns to `READY`.
  - A `cfg_req` still high in the cycle after `cfg_ack` starts a new transaction.
- `cfg_req` asserted before `init_done` is ignored until `READY`, then served normally.
- `busy` = 0 only in `READY`.

## Timing
- Reset values: `eng_enable`=0, `eng_add_reg`=0x80, `eng_data`=0, `cfg_ack`=0, `busy`=1, `init_done`=0, `err`=0, state=`PWRUP`.
- Reset asserted mid-transaction drops `eng_enable` asynchronously; the engine releases the bus.
- `eng_add_reg`/`eng_data` are stable from the rising edge that sets `eng_enable` until the edge that clears it.
- `eng_done` arriving in the same cycle the watchdog expires counts as success; `err` is not set.
- `eng_done` seen outside `WAIT` is ignored.
- Host latency from `cfg_req` in `READY` to `eng_enable`=1 is 2 cycles: `READY`→`ISSUE`→enable registered.
- Delay counters are 32-bit and count down to 0. A parameter value of 0 behaves as 1 cycle.

## Structure
- Shared package `tcs34725_pkg` holds:
  - register addresses: `REG_ENABLE`=0x00, `REG_ATIME`=0x01, `REG_CONTROL`=0x0F;
  - `CMD_BIT`=8'h80, `EN_PON`=0x01, `EN_AEN`=0x02;
  - the state encoding;
  - the init-table length (4).
- Sub-module `seq_timer` is a loadable 32-bit down-counter with `load`, `value` and an `expired` pulse. It is instantiated twice: once for delay/gap timing and once for the watchdog.

## Test plan
- **Reset behaviour:** assert `rst`=0 → all outputs at their reset values. Release → `eng_enable` first rises after `PWRUP_CYC`+1 cycles.
- **Init sequence:** use an engine model that returns `eng_done` 40 cycles after enable → writes (0x80,0x01), ≥`PON_CYC` idle, (0x80,0x03), (0x81,0xF6), (0x8F,0x01). Then `init_done`=1, `busy`=0, and `eng_enable` is low for `GAP_CYC` between writes.
- **Host write:** in `READY`, `cfg_req`=1 with reg 0x03, data 0x10 → `eng_add_reg`=0x83, `eng_data`=0x10. `cfg_ack` pulses once, after done plus `GAP_CYC`.
- **Early request:** `cfg_req` held from reset → not served until `init_done`, then exactly one transaction per ack while the request stays high.
- **Timeout:** engine model never pulses done → `eng_enable` drops after `TIMEOUT_CYC`, `err`=1, and init proceeds to the next entry.
- **Mid-transaction reset:** `rst` low during `WAIT` → `eng_enable`=0 immediately. After release, init restarts from entry 1.
